// File: rtl/vga_reg_write_scheduler_if.sv
// Requester, vblank and sprite-unit write-port signals of the VGA register write scheduler.
interface vga_reg_write_scheduler_if;
  logic        req0_valid;
  logic [5:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [5:0]  req1_addr;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        vblank_i;
  logic        vga_we;
  logic [5:0]  vga_addr;
  logic [15:0] vga_data;
  logic        busy;
  logic        err;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, vblank_i,
    input  req0_ready, req1_ready, vga_we, vga_addr, vga_data, busy, err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, vblank_i,
    output req0_ready, req1_ready, vga_we, vga_addr, vga_data, busy, err
  );
endinterface

// File: rtl/vga_reg_write_scheduler.sv
// Two-requester round-robin scheduler driving the sprite unit write port with a
// setup/strobe/hold sequence; position writes wait for vertical blank.
module vga_reg_write_scheduler #(
  parameter int          SETUP_CYCLES  = 1,
  parameter int          STROBE_CYCLES = 2,
  parameter int          HOLD_CYCLES   = 1,
  parameter logic [5:0]  POS_ADDR_LO   = 6'h20,
  parameter logic [5:0]  POS_ADDR_HI   = 6'h23
) (
  input  logic                       clk,
  input  logic                       reset,
  vga_reg_write_scheduler_if.slave   bus
);

  localparam int MAXC_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAXC   = (MAXC_A > HOLD_CYCLES) ? MAXC_A : HOLD_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DROP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          done;
  logic          ptr;
  logic          winner;
  logic [5:0]    addr_q;
  logic [15:0]   data_q;

  logic          e0, e1, gnt, gnt_id, gnt_unm;
  logic [5:0]    gnt_addr;
  logic [15:0]   gnt_data;

  function automatic logic is_pos(input logic [5:0] a);
    return (a >= POS_ADDR_LO) && (a <= POS_ADDR_HI);
  endfunction

  function automatic logic is_unm(input logic [5:0] a);
    return (a >= 6'h20) && !is_pos(a);
  endfunction

  // A position write that is waiting for vblank is simply not a candidate,
  // so it can never starve the other requester.
  assign e0       = bus.req0_valid && (!is_pos(bus.req0_addr) || bus.vblank_i);
  assign e1       = bus.req1_valid && (!is_pos(bus.req1_addr) || bus.vblank_i);
  assign gnt      = e0 || e1;
  assign gnt_id   = e1 && (!e0 || ptr);
  assign gnt_addr = gnt_id ? bus.req1_addr : bus.req0_addr;
  assign gnt_data = gnt_id ? bus.req1_data : bus.req0_data;
  assign gnt_unm  = is_unm(gnt_addr);
  assign done     = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt) state_nxt = gnt_unm ? DROP : SETUP;
      SETUP:   if (done) state_nxt = STROBE;
      STROBE:  if (done) state_nxt = HOLD;
      HOLD:    if (done) state_nxt = IDLE;
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter counts down to zero in each timed phase; addr/data latch only
  // on a real write so a dropped request leaves the port untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      ptr    <= 1'b0;
      winner <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (gnt) begin
          winner <= gnt_id;
          ptr    <= !gnt_id;
          if (!gnt_unm) begin
            addr_q <= gnt_addr;
            data_q <= gnt_data;
            cnt    <= CW'(SETUP_CYCLES - 1);
          end
        end
        SETUP:   cnt <= done ? CW'(STROBE_CYCLES - 1) : cnt - 1'b1;
        STROBE:  cnt <= done ? CW'(HOLD_CYCLES - 1)   : cnt - 1'b1;
        HOLD:    if (!done) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.vga_we     = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.busy       = (state != IDLE);
    bus.err        = 1'b0;
    case (state)
      STROBE: bus.vga_we = 1'b1;
      HOLD: if (done) begin
        bus.req0_ready = !winner;
        bus.req1_ready = winner;
      end
      DROP: begin
        bus.err        = 1'b1;
        bus.req0_ready = !winner;
        bus.req1_ready = winner;
      end
      default: ;
    endcase
  end

  assign bus.vga_addr = addr_q;
  assign bus.vga_data = data_q;

endmodule
